ldm_stm_sequencer: RTL and testbench
====================================

# ldm_stm_sequencer

Control-unit sequencer for block data transfers (load/store multiple). On `start` it latches a 16-bit register list, base address and addressing-mode bits, then walks the set bits lowest-first, issuing one register-file address and one word memory access per set bit over a req/ready handshake. It optionally produces a base-register writeback value and signals completion. It sits between the main control unit, the register file and the memory interface.

## Interface
Parameters:
- `ADDR_W`, 32, memory/base address width
- `WORD_BYTES`, 4, address increment per transfer

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  begin transfer; sampled only in IDLE
- `reg_list`  in  16  bit i set = transfer register i
- `base_addr`  in  ADDR_W  base register value
- `load`  in  1  1 = load (mem->reg), 0 = store
- `up`  in  1  1 = increment, 0 = decrement
- `pre`  in  1  1 = adjust before access, 0 = after
- `writeback`  in  1  request base writeback
- `mem_ready`  in  1  memory accepted/completed current access
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  store strobe (valid with `mem_req`)
- `mem_addr`  out  ADDR_W  word address of current access
- `reg_addr`  out  4  register-file index for current access
- `rf_we`  out  1  register-file write enable (loads)
- `wb_en`  out  1  base writeback strobe
- `wb_value`  out  ADDR_W  new base value
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SETUP, XFER, WB, DONE.
- IDLE: `start`=1 -> latch all inputs, go to SETUP. `start` outside IDLE ignored.
- SETUP (1 cycle): n = popcount(list). First address, always ascending: IA (up,!pre)=base; IB (up,pre)=base+4; DA (!up,!pre)=base-4n+4; DB (!up,pre)=base-4n. `wb_value` = up ? base+4n : base-4n (mod 2^ADDR_W). If n=0 -> DONE directly (no access, no writeback).
- XFER: `mem_req`=1, `mem_we`=!load, `reg_addr`=lowest set bit of pending list, `mem_addr`=current address; outputs held stable until `mem_ready`. In the `mem_ready` cycle: `rf_we`=load (load data taken from memory that cycle), clear that pending bit, address += WORD_BYTES. Pending empty after clear -> WB if writeback else DONE.
- WB: `wb_en`=1 for one cycle, then DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Lowest register always at lowest address; register order independent of `up`.
- Address arithmetic wraps modulo 2^ADDR_W; no fault raised.
- Reset (any state, incl. mid-XFER): -> IDLE, pending list cleared, every output 0 (`mem_addr`, `reg_addr`, `wb_value` = 0). Aborted transfer is not resumed.

## Timing
- `start` at edge k -> SETUP in cycle k+1 -> first `mem_req` in cycle k+2.
- Each transfer: 1 cycle minimum (`mem_ready` already high), extended one cycle per cycle `mem_ready` is low.
- n transfers, zero wait, writeback: `done` in cycle k+2+n+1; without writeback k+2+n.
- Empty list: `done` in cycle k+2.
- `busy`=1 from cycle k+1 through the DONE cycle inclusive; `start` may be re-asserted in the cycle after `done`.
- `rf_we`, `wb_en`, `done` are single-cycle pulses; `mem_req` never deasserts without `mem_ready`, except on reset.

## Structure
- Shared control-unit package: state enum (IDLE..DONE), `WORD_BYTES`, addressing-mode encoding {up,pre}.
- Sub-module `lowest_set_encoder`: combinational 16->4 priority encoder plus `any` flag, reused for `reg_addr` and pending-empty detect.
- Popcount, address adder and FSM in the top module.

## Test plan
- Store, list 0x0013, base 0x100, IA, no wb, ready always 1 -> accesses r0@0x100, r1@0x104, r4@0x108; `mem_we`=1; `done` 5 cycles after `start`.
- Load, list 0x8001, base 0x200, DB, wb -> r0@0x1F8, r15@0x1FC, `rf_we` twice, `wb_en` with `wb_value`=0x1F8, then `done`.
- IB and DA, list 0x00F0, base 0x1000 -> first addresses 0x1004 and 0x0FF4; wb values 0x1010 / 0x0FF0.
- Empty list with writeback set -> no `mem_req`, no `wb_en`, `done` 2 cycles after `start`.
- `mem_ready` low 3 cycles on second access -> `mem_addr`/`reg_addr` held stable; `start` pulsed mid-transfer ignored; `done` delayed by exactly 3.
- `rst_n` low during XFER -> all outputs 0 asynchronously; next `start` runs a full fresh transfer.

Source files
------------

// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared control-unit definitions for the load/store-multiple sequencer:
// FSM state encoding, default transfer stride and addressing-mode encoding.
package ldm_stm_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    localparam int DEFAULT_WORD_BYTES = 4;

    // Addressing mode as {up, pre}.
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_DB = 2'b01,
        MODE_IA = 2'b10,
        MODE_IB = 2'b11
    } addr_mode_e;

endpackage

// File: rtl/ldm_stm_sequencer_encoder.sv
// Lowest-set-bit priority encoder (16 -> 4) with a non-empty flag.
module lowest_set_encoder (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        any
);

    always_comb begin
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
    end

    assign any = |vec;

endmodule

// File: rtl/ldm_stm_sequencer.sv
// Load/store-multiple sequencer: walks a latched register list lowest-first,
// one memory word per set bit, with optional base-register writeback.
module ldm_stm_sequencer
    import ldm_stm_sequencer_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = DEFAULT_WORD_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              load,
    input  logic              up,
    input  logic              pre,
    input  logic              writeback,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        reg_addr,
    output logic              rf_we,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_value,
    output logic              busy,
    output logic              done,
    output seq_state_e        state_dbg
);

    // Memory handshake: mem_req/mem_addr/mem_we/reg_addr are held constant
    // while mem_req=1; the access completes in any cycle where mem_ready=1,
    // and only then do the outputs advance to the next register.

    seq_state_e        state, state_next;
    logic [15:0]       pending, pending_rest;
    logic [ADDR_W-1:0] base_q, cur_addr, wb_value_q;
    logic [ADDR_W-1:0] span, first_addr, wb_calc;
    addr_mode_e        mode_q;
    logic              load_q, wb_q;
    logic [4:0]        n;
    logic [3:0]        low_idx;
    logic              pend_any, rest_any;

    lowest_set_encoder u_enc (
        .vec (pending),
        .idx (low_idx),
        .any (pend_any)
    );

    assign pending_rest = pending & ~(16'b1 << low_idx);
    assign rest_any     = |pending_rest;

    always_comb begin
        n = '0;
        for (int i = 0; i < 16; i++) n = n + {4'b0, pending[i]};
    end

    assign span = ADDR_W'(n) * ADDR_W'(WORD_BYTES);

    // Every mode starts at the lowest address; the block is walked upwards.
    always_comb begin
        first_addr = base_q;
        case (mode_q)
            MODE_IA: first_addr = base_q;
            MODE_IB: first_addr = base_q + ADDR_W'(WORD_BYTES);
            MODE_DA: first_addr = base_q - span + ADDR_W'(WORD_BYTES);
            MODE_DB: first_addr = base_q - span;
            default: first_addr = base_q;
        endcase
    end

    assign wb_calc = mode_q[1] ? (base_q + span) : (base_q - span);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SETUP;
            ST_SETUP: state_next = pend_any ? ST_XFER : ST_DONE;
            ST_XFER:  if (mem_ready && !rest_any) state_next = wb_q ? ST_WB : ST_DONE;
            ST_WB:    state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        reg_addr = '0;
        rf_we    = 1'b0;
        wb_en    = 1'b0;
        done     = 1'b0;
        case (state)
            ST_XFER: begin
                mem_req  = 1'b1;
                mem_we   = !load_q;
                mem_addr = cur_addr;
                reg_addr = low_idx;
                rf_we    = load_q && mem_ready;
            end
            ST_WB:   wb_en = 1'b1;
            ST_DONE: done  = 1'b1;
            default: ;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign wb_value  = wb_value_q;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending    <= '0;
            base_q     <= '0;
            cur_addr   <= '0;
            wb_value_q <= '0;
            mode_q     <= MODE_DA;
            load_q     <= 1'b0;
            wb_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    pending <= reg_list;
                    base_q  <= base_addr;
                    mode_q  <= addr_mode_e'({up, pre});
                    load_q  <= load;
                    wb_q    <= writeback;
                end
                ST_SETUP: begin
                    cur_addr   <= first_addr;
                    wb_value_q <= wb_calc;
                end
                ST_XFER: if (mem_ready) begin
                    pending  <= pending_rest;
                    cur_addr <= cur_addr + ADDR_W'(WORD_BYTES);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer with hand-computed per-cycle expectations.
module tb_ldm_stm_sequencer;
    import ldm_stm_sequencer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic        load, up, pre, writeback, mem_ready;
    logic        mem_req, mem_we, rf_we, wb_en, busy, done;
    logic [31:0] mem_addr, wb_value;
    logic [3:0]  reg_addr;
    seq_state_e  state_dbg;

    int checks = 0;
    int errors = 0;

    ldm_stm_sequencer #(.ADDR_W(32), .WORD_BYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .reg_list  (reg_list),
        .base_addr (base_addr),
        .load      (load),
        .up        (up),
        .pre       (pre),
        .writeback (writeback),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .reg_addr  (reg_addr),
        .rf_we     (rf_we),
        .wb_en     (wb_en),
        .wb_value  (wb_value),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_cyc(input string tag, input logic req, input logic we,
                           input logic [31:0] addr, input logic [3:0] ra,
                           input logic rfwe, input logic wbe, input logic bsy,
                           input logic dn);
        chk({tag, ".mem_req"},  {31'b0, mem_req}, {31'b0, req});
        chk({tag, ".mem_we"},   {31'b0, mem_we},  {31'b0, we});
        chk({tag, ".mem_addr"}, mem_addr,         addr);
        chk({tag, ".reg_addr"}, {28'b0, reg_addr}, {28'b0, ra});
        chk({tag, ".rf_we"},    {31'b0, rf_we},   {31'b0, rfwe});
        chk({tag, ".wb_en"},    {31'b0, wb_en},   {31'b0, wbe});
        chk({tag, ".busy"},     {31'b0, busy},    {31'b0, bsy});
        chk({tag, ".done"},     {31'b0, done},    {31'b0, dn});
    endtask

    // driver: present a transfer for one edge, return sampling the SETUP cycle
    task automatic start_xfer(input logic [15:0] lst, input logic [31:0] base,
                              input logic ld, input logic u, input logic p,
                              input logic wb);
        @(negedge clk);
        reg_list  = lst;
        base_addr = base;
        load      = ld;
        up        = u;
        pre       = p;
        writeback = wb;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic step(input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        #1;
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; reg_list = '0; base_addr = '0;
        load = 1'b0; up = 1'b0; pre = 1'b0; writeback = 1'b0; mem_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        exp_cyc("reset", 0, 0, 32'h0, 4'h0, 0, 0, 0, 0);
        chk("reset.wb_value", wb_value, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // IA store, list 0x0013, no writeback
        start_xfer(16'h0013, 32'h100, 0, 1, 0, 0);
        exp_cyc("t1.setup", 0, 0, 32'h0, 4'h0, 0, 0, 1, 0);
        step(1); exp_cyc("t1.x0", 1, 1, 32'h100, 4'd0, 0, 0, 1, 0);
        chk("t1.wb_value", wb_value, 32'h10C);
        step(1); exp_cyc("t1.x1", 1, 1, 32'h104, 4'd1, 0, 0, 1, 0);
        step(1); exp_cyc("t1.x2", 1, 1, 32'h108, 4'd4, 0, 0, 1, 0);
        step(1); exp_cyc("t1.done", 0, 0, 32'h0, 4'd0, 0, 0, 1, 1);
        step(1); exp_cyc("t1.idle", 0, 0, 32'h0, 4'd0, 0, 0, 0, 0);

        // DB load with writeback, list 0x8001
        start_xfer(16'h8001, 32'h200, 1, 0, 1, 1);
        exp_cyc("t2.setup", 0, 0, 32'h0, 4'h0, 0, 0, 1, 0);
        step(1); exp_cyc("t2.x0", 1, 0, 32'h1F8, 4'd0, 1, 0, 1, 0);
        step(1); exp_cyc("t2.x1", 1, 0, 32'h1FC, 4'd15, 1, 0, 1, 0);
        step(1); exp_cyc("t2.wb", 0, 0, 32'h0, 4'd0, 0, 1, 1, 0);
        chk("t2.wb_value", wb_value, 32'h1F8);
        step(1); exp_cyc("t2.done", 0, 0, 32'h0, 4'd0, 0, 0, 1, 1);
        step(1); exp_cyc("t2.idle", 0, 0, 32'h0, 4'd0, 0, 0, 0, 0);

        // IB store, list 0x00F0, no writeback
        start_xfer(16'h00F0, 32'h1000, 0, 1, 1, 0);
        exp_cyc("t3.setup", 0, 0, 32'h0, 4'h0, 0, 0, 1, 0);
        step(1); exp_cyc("t3.x0", 1, 1, 32'h1004, 4'd4, 0, 0, 1, 0);
        chk("t3.wb_value", wb_value, 32'h1010);
        step(1); exp_cyc("t3.x1", 1, 1, 32'h1008, 4'd5, 0, 0, 1, 0);
        step(1); exp_cyc("t3.x2", 1, 1, 32'h100C, 4'd6, 0, 0, 1, 0);
        step(1); exp_cyc("t3.x3", 1, 1, 32'h1010, 4'd7, 0, 0, 1, 0);
        step(1); exp_cyc("t3.done", 0, 0, 32'h0, 4'd0, 0, 0, 1, 1);

        // DA load with writeback, list 0x00F0
        start_xfer(16'h00F0, 32'h1000, 1, 0, 0, 1);
        exp_cyc("t4.setup", 0, 0, 32'h0, 4'h0, 0, 0, 1, 0);
        step(1); exp_cyc("t4.x0", 1, 0, 32'h0FF4, 4'd4, 1, 0, 1, 0);
        chk("t4.wb_value", wb_value, 32'h0FF0);
        step(1); exp_cyc("t4.x1", 1, 0, 32'h0FF8, 4'd5, 1, 0, 1, 0);
        step(1); exp_cyc("t4.x2", 1, 0, 32'h0FFC, 4'd6, 1, 0, 1, 0);
        step(1); exp_cyc("t4.x3", 1, 0, 32'h1000, 4'd7, 1, 0, 1, 0);
        step(1); exp_cyc("t4.wb", 0, 0, 32'h0, 4'd0, 0, 1, 1, 0);
        step(1); exp_cyc("t4.done", 0, 0, 32'h0, 4'd0, 0, 0, 1, 1);
        step(1); exp_cyc("t4.idle", 0, 0, 32'h0, 4'd0, 0, 0, 0, 0);

        // empty list with writeback requested
        start_xfer(16'h0000, 32'h2000, 0, 1, 0, 1);
        exp_cyc("t5.setup", 0, 0, 32'h0, 4'h0, 0, 0, 1, 0);
        step(1); exp_cyc("t5.done", 0, 0, 32'h0, 4'd0, 0, 0, 1, 1);
        step(1); exp_cyc("t5.idle", 0, 0, 32'h0, 4'd0, 0, 0, 0, 0);

        // wait states on the second access, start pulsed mid-transfer
        start_xfer(16'h0007, 32'h300, 0, 1, 0, 0);
        exp_cyc("t6.setup", 0, 0, 32'h0, 4'h0, 0, 0, 1, 0);
        step(1); exp_cyc("t6.x0", 1, 1, 32'h300, 4'd0, 0, 0, 1, 0);
        step(0); exp_cyc("t6.w1", 1, 1, 32'h304, 4'd1, 0, 0, 1, 0);
        @(negedge clk);
        mem_ready = 1'b0; start = 1'b1; reg_list = 16'hFFFF; base_addr = 32'h9000;
        #1; exp_cyc("t6.w2", 1, 1, 32'h304, 4'd1, 0, 0, 1, 0);
        @(negedge clk);
        mem_ready = 1'b0; start = 1'b0;
        #1; exp_cyc("t6.w3", 1, 1, 32'h304, 4'd1, 0, 0, 1, 0);
        step(1); exp_cyc("t6.x1", 1, 1, 32'h304, 4'd1, 0, 0, 1, 0);
        step(1); exp_cyc("t6.x2", 1, 1, 32'h308, 4'd2, 0, 0, 1, 0);
        step(1); exp_cyc("t6.done", 0, 0, 32'h0, 4'd0, 0, 0, 1, 1);
        step(1); exp_cyc("t6.idle", 0, 0, 32'h0, 4'd0, 0, 0, 0, 0);
        step(1); exp_cyc("t6.idle2", 0, 0, 32'h0, 4'd0, 0, 0, 0, 0);

        // asynchronous reset in the middle of a load, then a fresh transfer
        start_xfer(16'hFFFF, 32'h400, 1, 1, 0, 1);
        exp_cyc("t7.setup", 0, 0, 32'h0, 4'h0, 0, 0, 1, 0);
        step(1); exp_cyc("t7.x0", 1, 0, 32'h400, 4'd0, 1, 0, 1, 0);
        step(1); exp_cyc("t7.x1", 1, 0, 32'h404, 4'd1, 1, 0, 1, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1; exp_cyc("t7.rst", 0, 0, 32'h0, 4'd0, 0, 0, 0, 0);
        chk("t7.rst.wb_value", wb_value, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1; exp_cyc("t7.idle", 0, 0, 32'h0, 4'd0, 0, 0, 0, 0);
        start_xfer(16'h0003, 32'h500, 0, 1, 0, 0);
        exp_cyc("t8.setup", 0, 0, 32'h0, 4'h0, 0, 0, 1, 0);
        step(1); exp_cyc("t8.x0", 1, 1, 32'h500, 4'd0, 0, 0, 1, 0);
        step(1); exp_cyc("t8.x1", 1, 1, 32'h504, 4'd1, 0, 0, 1, 0);
        step(1); exp_cyc("t8.done", 0, 0, 32'h0, 4'd0, 0, 0, 1, 1);
        chk("t8.wb_value", wb_value, 32'h508);
        step(1); exp_cyc("t8.idle", 0, 0, 32'h0, 4'd0, 0, 0, 0, 0);

        // report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
